// File: rtl/program_loader.sv
// program_loader
//   Receives a length-prefixed byte image on a valid/ready stream, writes the
//   payload into a byte-wide instruction memory, verifies a trailing XOR
//   checksum and then releases the downstream CPU from reset.
//
//   Stream format: LEN[15:8], LEN[7:0], LEN payload bytes, XOR checksum byte.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : one-cycle request to begin a load (honoured in IDLE/RUN/ERROR)
//   in_data    : stream byte
//   in_valid   : stream byte valid
//   in_ready   : loader accepts a byte this cycle
//   mem_we     : registered one-cycle byte-write strobe
//   mem_addr   : byte write address
//   mem_data   : byte write data
//   cpu_hold   : holds the CPU in reset (low only in RUN)
//   busy       : load in progress
//   done       : image loaded and verified, CPU running
//   error      : load failed (oversize length or bad checksum)
//   byte_count : payload bytes written so far
module program_loader #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   byte_count
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [15:0] DEPTH_C = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     length_q, length_d;
  logic [15:0]     count_q, count_d;
  logic [7:0]      csum_q, csum_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      data_q, data_d;

  logic            accept;
  logic [15:0]     count_inc;
  logic [15:0]     len_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      length_q <= '0;
      count_q  <= '0;
      csum_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      count_q  <= count_d;
      csum_q   <= csum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Stream side and status flags decode directly from the state register.
  always_comb begin
    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
               (state_q == S_LOAD)   || (state_q == S_CHECK);
    busy     = in_ready;
    done     = (state_q == S_RUN);
    error    = (state_q == S_ERROR);
    cpu_hold = (state_q != S_RUN);
  end

  assign accept   = in_valid && in_ready;
  // Saturate at DEPTH; the LEN_LO length check keeps the count from reaching it
  // except on the last byte of a maximum-size image.
  assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + 16'd1;
  assign len_full  = {length_q[15:8], in_data};

  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    count_d  = count_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    unique case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_d  = S_LEN_HI;
          length_d = '0;
          count_d  = '0;
          csum_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          length_d[15:8] = in_data;
          state_d        = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          length_d = len_full;
          if ({1'b0, len_full} > DEPTH_W) begin
            state_d = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = count_q[AW-1:0];
          data_d  = in_data;
          count_d = count_inc;
          csum_d  = csum_q ^ in_data;
          if (count_inc == length_q) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_RUN : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   byte_count;

  program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int writes     = 0;

  logic [AW+7:0] exp_q[$];
  logic [7:0]    imem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_we must match the next expected (addr,data).
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      logic [AW+7:0] e;
      writes++;
      imem[mem_addr] = mem_data;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          miscompares++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   mem_addr, mem_data, e[AW+7:8], e[7:0]);
        end
      end
    end
  end

  task automatic expect_write(input int a, input logic [7:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte after 'gap' idle cycles; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      miscompares++;
      vectors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset    = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    #1;
    // Reset state
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_cpu_hold", cpu_hold, 1);
    check("idle_in_ready", in_ready, 0);

    // Nominal load
    pulse_start();
    check("nom_busy", busy, 1);
    check("nom_hold", cpu_hold, 1);
    check("nom_ready", in_ready, 1);
    send(8'h00, 0);
    send(8'h04, 0);
    expect_write(0, 8'h8C); expect_write(1, 8'h01);
    expect_write(2, 8'h00); expect_write(3, 8'h2C);
    send(8'h8C, 0); send(8'h01, 0); send(8'h00, 0); send(8'h2C, 0);
    @(negedge clk);
    check("nom_byte_count", byte_count, 4);
    check("nom_check_busy", busy, 1);
    send(8'hA1, 0);
    settle();
    check("nom_done", done, 1);
    check("nom_hold_low", cpu_hold, 0);
    check("nom_error", error, 0);
    check("nom_busy_low", busy, 0);
    check("nom_pending", exp_q.size(), 0);
    check("nom_writes", writes, 4);

    // Reload from RUN with a bad checksum
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("reload_hold", cpu_hold, 1);
    check("reload_count", byte_count, 0);
    w0 = writes;
    send(8'h00, 0); send(8'h04, 0);
    expect_write(0, 8'h8C); expect_write(1, 8'h01);
    expect_write(2, 8'h00); expect_write(3, 8'h2C);
    send(8'h8C, 0); send(8'h01, 0); send(8'h00, 0); send(8'h2C, 0);
    send(8'h00, 0);
    settle();
    check("badck_error", error, 1);
    check("badck_hold", cpu_hold, 1);
    check("badck_done", done, 0);
    check("badck_writes", writes - w0, 4);

    // Oversize length 513
    pulse_start();
    w0 = writes;
    send(8'h02, 0); send(8'h01, 0);
    settle();
    check("over_error", error, 1);
    check("over_writes", writes - w0, 0);

    // Length exactly DEPTH is accepted, then abandoned by reset
    pulse_start();
    send(8'h02, 0); send(8'h00, 0);
    @(negedge clk);
    check("max_len_busy", busy, 1);
    check("max_len_error", error, 0);
    reset = 1'b0;
    #1;
    check("max_len_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Zero length, good then bad checksum
    pulse_start();
    w0 = writes;
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    settle();
    check("zero_done", done, 1);
    check("zero_writes", writes - w0, 0);
    pulse_start();
    send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
    settle();
    check("zero_bad_error", error, 1);
    check("zero_bad_done", done, 0);

    // Stalled stream: random gaps between payload bytes
    pulse_start();
    w0 = writes;
    send(8'h00, 1); send(8'h05, 2);
    expect_write(0, 8'h11); expect_write(1, 8'h22); expect_write(2, 8'h33);
    expect_write(3, 8'h44); expect_write(4, 8'h55);
    send(8'h11, $urandom_range(0, 3)); send(8'h22, $urandom_range(0, 3));
    send(8'h33, $urandom_range(0, 3)); send(8'h44, $urandom_range(0, 3));
    send(8'h55, $urandom_range(0, 3));
    send(8'h11, 2);
    settle();
    check("stall_done", done, 1);
    check("stall_writes", writes - w0, 5);
    check("stall_count", byte_count, 5);

    // Reset after the second payload byte
    pulse_start();
    w0 = writes;
    send(8'h00, 0); send(8'h04, 0);
    expect_write(0, 8'hAA); expect_write(1, 8'hBB);
    send(8'hAA, 0); send(8'hBB, 0);
    in_valid = 1'b1;
    in_data  = 8'hCC;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_hold", cpu_hold, 1);
    check("midrst_busy", busy, 0);
    check("midrst_we", mem_we, 0);
    check("midrst_count", byte_count, 0);
    check("midrst_mem_addr", mem_addr, 0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_idle_ready", in_ready, 0);
    check("midrst_writes", writes - w0, 2);
    check("midrst_mem0", imem[0], 8'hAA);
    check("midrst_mem1", imem[1], 8'hBB);

    // Second image after reset loads from address 0
    pulse_start();
    expect_write(0, 8'h5A); expect_write(1, 8'hA5);
    send(8'h00, 0); send(8'h02, 0); send(8'h5A, 0); send(8'hA5, 0); send(8'hFF, 0);
    settle();
    check("img2_done", done, 1);
    check("img2_mem0", imem[0], 8'h5A);
    check("img2_mem1", imem[1], 8'hA5);
    check("final_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
